regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Instruction sequencer that drives the register file from the opposite side of its port set. It owns the write port (replaceSel/replaceData), drives both read selects (A_sel/B_sel) and takes back the read data (A/B). It accepts one micro-instruction at a time over a valid/ready handshake, reads operands, computes an 8-bit result and writes it back. It is the controller between the instruction source and the register file in the datapath.

## Interface
- DATA_W, 8, register/data width
- SEL_W, 4, register select width (16 registers)
- clk  input  1  system clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  instruction present
- instr_ready  output  1  sequencer can accept an instruction
- opcode  input  3  operation (see Operation)
- dst, src_a, src_b  input  SEL_W each  destination and source register indices
- imm  input  DATA_W  immediate for LOADI
- A_sel, B_sel  output  SEL_W each  register file read selects
- A, B  input  DATA_W each  register file read data (combinational w.r.t. A_sel/B_sel)
- replaceSel  output  SEL_W  register file write select
- replaceData  output  DATA_W  register file write data
- done  output  1  one-cycle pulse: the instruction's write-back is on the write port this cycle
- result  output  DATA_W  last computed result
- zero, carry  output  1 each  flags of last result

## Operation
- The register file writes replaceData into register replaceSel on every rising clk and has no write enable.
- Outside a real write-back, the sequencer drives refresh mode: replaceSel = A_sel and replaceData = A. The selected register rewrites its own value.
- Opcodes:
  - 000 NOP: no write; result = 0.
  - 001 LOADI: result = imm.
  - 010 ADD: result = opA + opB, modulo 256; carry = bit 8 of the sum.
  - 011 SUB: result = opA − opB, modulo 256; carry = borrow (opA < opB).
  - 100 AND, 101 OR, 110 XOR: bitwise on opA and opB.
  - 111 MOV: result = opA.
- carry = 0 for every opcode except ADD and SUB. zero = (result == 0).
- FSM states:
  - IDLE: instr_ready = 1. On instr_valid, latch all instruction fields and go to READ.
  - READ: A_sel = src_a, B_sel = src_b. Latch A into opA and B into opB at the end of the cycle. Go to EXEC.
  - EXEC: compute into the result register and update flags. Go to WRITE.
  - WRITE: replaceSel = dst, replaceData = result, done = 1. For NOP, stay in refresh mode instead but still pulse done. Go to IDLE.
- instr_ready is 0 in READ, EXEC and WRITE. Instructions offered there stall and must be held by the source.

## Timing
- Handshake: accept at rising edge t0 when instr_valid && instr_ready.
  - READ is the cycle after t0.
  - Operands latch at t1.
  - The result register is valid from t1+1 (EXEC output) and is held until the next EXEC.
  - WRITE is the cycle after t2; done is high then.
  - The register updates at edge t3, when the FSM also returns to IDLE.
- Latency is 3 cycles from accept to the register updating. Throughput is 1 instruction per 4 cycles.
- Read-after-write needs no forwarding: a write lands at t3, before the next instruction's READ.
- A_sel and B_sel hold their last values in EXEC, WRITE and IDLE.
- Reset:
  - While reset is high, instr_ready = 0.
  - The state is IDLE and A_sel = B_sel = 0.
  - opA, opB, result, zero, carry and done are all 0.
  - Outputs stay in refresh mode on register 0.
  - instr_ready rises in the first cycle after reset deasserts.
- Reset mid-instruction, in any state including WRITE: the instruction is aborted and no write occurs. The register file contents are untouched, because it is not reset and refresh mode preserves register 0.
- If instr_valid and reset are high together, reset wins and the instruction is not accepted.

## Structure
- Shared package regfile_seq_pkg holds:
  - DATA_W and SEL_W defaults
  - the opcode constants (OP_NOP … OP_MOV)
  - the FSM state encoding (S_IDLE, S_READ, S_EXEC, S_WRITE)
- One sub-module, seq_alu: combinational; inputs opcode, opA, opB, imm; outputs result, zero, carry. The sequencer registers its outputs in EXEC.

## Test plan
- Reset: hold reset for 2 cycles.
  - During reset: instr_ready = 0, done = 0, replaceSel = A_sel = 0.
  - After release: instr_ready = 1 on the next cycle.
- LOADI r0 = 0xAA, then MOV r6 = r0.
  - done pulses 3 cycles after each accept.
  - MOV result = 0xAA and zero = 0.
- LOADI r0 = 0xAA, LOADI r1 = 0xBB, ADD r2 = r0 + r1.
  - result = 0x65, carry = 1.
  - MOV r7 = r2 reads back 0x65.
- SUB r3 = r0 − r0: result = 0x00, zero = 1, carry = 0.
- SUB r4 = r0 − r1 (0xAA − 0xBB): result = 0xEF, carry = 1.
- instr_valid held high with two instructions, LOADI r5 = 0x11 then ADD r5 = r5 + r5.
  - The second is accepted exactly 4 cycles after the first.
  - Result = 0x22.
- Reset asserted during EXEC of LOADI r8 = 0x55, with r8 previously 0x00 and r0 = 0xAA.
  - No done pulse.
  - Afterwards MOV reads r8 = 0x00 and r0 = 0xAA.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared widths, opcode constants and FSM state encoding for the register-file sequencer.
package regfile_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 3'b000;
  localparam logic [OP_W-1:0] OP_LOADI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OP_W-1:0] OP_AND   = 3'b100;
  localparam logic [OP_W-1:0] OP_OR    = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b110;
  localparam logic [OP_W-1:0] OP_MOV   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } seqStateT;

endpackage

// File: rtl/regfile_sequencer_alu.sv
// Combinational ALU for the sequencer: result plus zero/carry flags for one micro-instruction.
module seq_alu
  import regfile_seq_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  localparam int unsigned WIDE_W = DATA_W + 1;

  logic [WIDE_W-1:0] wide;

  // Bit DATA_W of the widened add is the carry; of the widened subtract it is the borrow.
  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    unique case (opcode)
      OP_NOP:   result = '0;
      OP_LOADI: result = imm;
      OP_ADD: begin
        wide   = WIDE_W'(opA) + WIDE_W'(opB);
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_SUB: begin
        wide   = WIDE_W'(opA) - WIDE_W'(opB);
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_AND:   result = opA & opB;
      OP_OR:    result = opA | opB;
      OP_XOR:   result = opA ^ opB;
      default:  result = opA;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// Micro-instruction sequencer: reads two registers, computes via seq_alu, writes back.
// The register file has no write enable, so idle cycles refresh the A-selected register.
module regfile_sequencer
  import regfile_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [SEL_W-1:0]  dst,
  input  logic [SEL_W-1:0]  src_a,
  input  logic [SEL_W-1:0]  src_b,
  input  logic [DATA_W-1:0] imm,
  output logic [SEL_W-1:0]  A_sel,
  output logic [SEL_W-1:0]  B_sel,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [SEL_W-1:0]  replaceSel,
  output logic [DATA_W-1:0] replaceData,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  seqStateT state;
  seqStateT nextState;

  logic [OP_W-1:0]   opQ;
  logic [SEL_W-1:0]  dstQ;
  logic [DATA_W-1:0] immQ;
  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] aluResult;
  logic              aluZero;
  logic              aluCarry;
  logic              accept;

  seq_alu uAlu (
    .opcode (opQ),
    .opA    (opA),
    .opB    (opB),
    .imm    (immQ),
    .result (aluResult),
    .zero   (aluZero),
    .carry  (aluCarry)
  );

  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  // Reset gates ready, done and the write-back so an aborted instruction never lands.
  always_comb begin
    nextState   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    replaceSel  = A_sel;
    replaceData = A;
    if (!reset) begin
      unique case (state)
        S_IDLE: begin
          instr_ready = 1'b1;
          if (instr_valid) nextState = S_READ;
        end
        S_READ:  nextState = S_EXEC;
        S_EXEC:  nextState = S_WRITE;
        S_WRITE: begin
          done = 1'b1;
          if (opQ != OP_NOP) begin
            replaceSel  = dstQ;
            replaceData = result;
          end
          nextState = S_IDLE;
        end
        default: nextState = S_IDLE;
      endcase
    end
  end

  // Instruction latch, operand capture and result/flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      opQ    <= OP_NOP;
      dstQ   <= '0;
      immQ   <= '0;
      A_sel  <= '0;
      B_sel  <= '0;
      opA    <= '0;
      opB    <= '0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            opQ   <= opcode;
            dstQ  <= dst;
            immQ  <= imm;
            A_sel <= src_a;
            B_sel <= src_b;
          end
        end
        S_READ: begin
          opA <= A;
          opB <= B;
        end
        S_EXEC: begin
          result <= aluResult;
          zero   <= aluZero;
          carry  <= aluCarry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomised self-checking bench for regfile_sequencer against a 16-entry register file
// and a timing/arithmetic model derived from the instruction rules.
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        opcode;
  logic [3:0]        dst, src_a, src_b;
  logic [7:0]        imm;
  logic [3:0]        A_sel, B_sel, replaceSel;
  logic [7:0]        A, B, replaceData, result;
  logic              done, zero, carry;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .dst(dst), .src_a(src_a), .src_b(src_b), .imm(imm),
    .A_sel(A_sel), .B_sel(B_sel), .A(A), .B(B),
    .replaceSel(replaceSel), .replaceData(replaceData),
    .done(done), .result(result), .zero(zero), .carry(carry)
  );

  // Register file environment: no write enable, combinational reads.
  logic [7:0] rf [16] = '{default: 8'h00};
  always @(posedge clk) rf[replaceSel] <= replaceData;
  assign A = rf[A_sel];
  assign B = rf[B_sel];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int op, input int a, input int b, input int im,
                                output int r, output int z, output int c);
    c = 0;
    case (op)
      0: r = 0;
      1: r = im;
      2: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      3: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = a;
    endcase
    z = (r == 0) ? 1 : 0;
  endfunction

  // Model: phase counts cycles since accept (0 = idle, 3 = write-back cycle).
  int phase = 0;
  int mOp = 0, mDst = 0, mSa = 0, mSb = 0;
  int pendRes = 0, pendZ = 0, pendC = 0;
  int expRes = 0, expZ = 0, expC = 0;
  int gold [16] = '{default: 0};
  bit acceptNext = 1'b0;
  bit rstSeen = 1'b0;
  int cyc = 0;
  int acceptCyc[$];
  int lastDoneCyc = 0;
  int doneCount = 0;
  int doneRes = 0, doneZ = 0, doneC = 0;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      chk("instr_ready", int'(instr_ready), (phase == 0 && !reset) ? 1 : 0);
      chk("done", int'(done), (phase == 3 && !reset) ? 1 : 0);
      if (done) begin
        doneCount++;
        lastDoneCyc = cyc;
        doneRes = int'(result);
        doneZ = int'(zero);
        doneC = int'(carry);
      end
      if (phase == 3 && !reset && mOp != 0) begin
        chk("write_sel", int'(replaceSel), mDst);
        chk("write_data", int'(replaceData), expRes);
      end else begin
        chk("refresh_sel", int'(replaceSel), int'(A_sel));
        chk("refresh_data", int'(replaceData), int'(rf[A_sel]));
      end
      chk("result", int'(result), expRes);
      chk("zero", int'(zero), expZ);
      chk("carry", int'(carry), expC);
      if (phase == 1) begin
        chk("a_sel_read", int'(A_sel), mSa);
        chk("b_sel_read", int'(B_sel), mSb);
      end
      if (rstSeen) begin
        chk("a_sel_reset", int'(A_sel), 0);
        chk("b_sel_reset", int'(B_sel), 0);
      end
      for (int i = 0; i < 16; i++) chk($sformatf("reg%0d", i), int'(rf[i]), gold[i]);

      acceptNext = 1'b0;
      if (reset) begin
        phase = 0; expRes = 0; expZ = 0; expC = 0; rstSeen = 1'b1;
      end else begin
        rstSeen = 1'b0;
        case (phase)
          0: if (instr_valid) begin
            acceptNext = 1'b1;
            mOp = int'(opcode); mDst = int'(dst); mSa = int'(src_a); mSb = int'(src_b);
            model(mOp, gold[mSa], gold[mSb], int'(imm), pendRes, pendZ, pendC);
            acceptCyc.push_back(cyc);
            phase = 1;
          end
          1: phase = 2;
          2: begin expRes = pendRes; expZ = pendZ; expC = pendC; phase = 3; end
          default: begin
            if (mOp != 0) gold[mDst] = pendRes;
            phase = 0;
          end
        endcase
      end
    end
  end

  // Offer an instruction; returns #1 after the accepting edge (or after finishing if waitDone).
  task automatic issue(input int op, input int d, input int sa, input int sb,
                       input int im, input bit waitDone);
    bit took = 1'b0;
    opcode = 3'(op); dst = 4'(d); src_a = 4'(sa); src_b = 4'(sb); imm = 8'(im);
    instr_valid = 1'b1;
    for (int i = 0; i < 12 && !took; i++) begin
      @(posedge clk);
      if (acceptNext) took = 1'b1;
    end
    #1;
    chk("accept_timeout", int'(took), 1);
    if (waitDone) begin
      instr_valid = 1'b0;
      for (int i = 0; i < 12 && phase != 0; i++) @(posedge clk);
      #1;
      chk("finish_timeout", (phase == 0) ? 1 : 0, 1);
    end
  endtask

  task automatic pin(input string name, input int res, input int z, input int c);
    chk({name, "_res"}, doneRes, res);
    chk({name, "_zero"}, doneZ, z);
    chk({name, "_carry"}, doneC, c);
    chk({name, "_latency"}, lastDoneCyc - acceptCyc[$], 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, dc;
    reset = 1'b1; instr_valid = 1'b0; opcode = '0;
    dst = '0; src_a = '0; src_b = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    issue(1, 0, 0, 0, 8'hAA, 1'b1); pin("loadi_r0", 8'hAA, 0, 0);
    issue(7, 6, 0, 0, 0, 1'b1);     pin("mov_r6", 8'hAA, 0, 0);
    issue(1, 1, 0, 0, 8'hBB, 1'b1); pin("loadi_r1", 8'hBB, 0, 0);
    issue(2, 2, 0, 1, 0, 1'b1);     pin("add_r2", 8'h65, 0, 1);
    issue(7, 7, 2, 0, 0, 1'b1);     pin("mov_r7", 8'h65, 0, 0);
    issue(3, 3, 0, 0, 0, 1'b1);     pin("sub_r3", 8'h00, 1, 0);
    issue(3, 4, 0, 1, 0, 1'b1);     pin("sub_r4", 8'hEF, 0, 1);

    // Back-to-back with instr_valid held high across the stall.
    issue(1, 5, 0, 0, 8'h11, 1'b0);
    a0 = acceptCyc[$];
    issue(2, 5, 5, 5, 0, 1'b1);
    a1 = acceptCyc[$];
    chk("b2b_spacing", a1 - a0, 4);
    pin("add_r5", 8'h22, 0, 0);

    // Reset during EXEC aborts the write.
    issue(1, 8, 0, 0, 8'h55, 1'b0);
    instr_valid = 1'b0;
    dc = doneCount;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", doneCount, dc);
    issue(7, 9, 8, 0, 0, 1'b1);  pin("mov_r8", 8'h00, 1, 0);
    issue(7, 10, 0, 0, 0, 1'b1); pin("mov_r0", 8'hAA, 0, 0);

    // Random instruction stream with random idle gaps and stalls.
    for (int n = 0; n < 150; n++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        instr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 12 && phase != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain", phase, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
